// File: rtl/usb_fifo_drain.sv
// usb_fifo_drain
//   Read side of the external USB data FIFO. Pulls 16-bit words out of the
//   FIFO one at a time and writes them to the FX2 slave-FIFO endpoint,
//   honouring endpoint-full back-pressure. When a run stops and the FIFO has
//   stayed empty for FLUSH_WAIT cycles, any partial packet is committed with
//   PKTEND and DataTransmitDone is pulsed.
//
// Ports
//   Clk, reset        clock, synchronous active-high reset
//   UsbStartStop      run active level
//   FifoData/Empty    FIFO read data (valid cycle after FifoRd_en) / empty flag
//   FifoRd_en         FIFO read strobe
//   UsbFull_n         FX2 FLAGB, low = endpoint full
//   UsbFd             FX2 data bus
//   UsbSlwr_n         FX2 write strobe (active low)
//   UsbPktend_n       FX2 packet-end strobe (active low)
//   DataTransmitDone  one-cycle pulse after a stopped run is flushed
module usb_fifo_drain #(
  parameter int PKT_WORDS  = 256,
  parameter int FLUSH_WAIT = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        UsbStartStop,
  input  logic [15:0] FifoData,
  input  logic        FifoEmpty,
  output logic        FifoRd_en,
  input  logic        UsbFull_n,
  output logic [15:0] UsbFd,
  output logic        UsbSlwr_n,
  output logic        UsbPktend_n,
  output logic        DataTransmitDone
);

  localparam int CW = $clog2(PKT_WORDS);
  localparam int TW = $clog2(FLUSH_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LOAD, S_WAITF, S_WR, S_FLUSH, S_PKTEND, S_DONE
  } state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_wcnt;
  logic [TW-1:0] r_ftmr;
  logic          r_run_seen;
  logic          r_rd_en, r_slwr_n, r_pktend_n, r_done;
  logic [15:0]   r_fd;
  logic          w_pkt_fire;

  // PKTEND only fires once the endpoint can accept the commit
  assign w_pkt_fire = (r_state == S_PKTEND) && UsbFull_n;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!FifoEmpty)                       w_nxt = S_RD;
        else if (!UsbStartStop && r_run_seen) w_nxt = S_FLUSH;
      end
      S_RD:    w_nxt = S_LOAD;
      // full flag sampled here so its FX2-side lag is absorbed before WR
      S_LOAD:  w_nxt = UsbFull_n ? S_WR : S_WAITF;
      S_WAITF: if (UsbFull_n) w_nxt = S_WR;
      S_WR:    w_nxt = !FifoEmpty ? S_RD : S_IDLE;
      S_FLUSH: begin
        if (!FifoEmpty)                          w_nxt = S_RD;
        else if (UsbStartStop)                   w_nxt = S_IDLE;
        else if (r_ftmr == TW'(FLUSH_WAIT - 1))  w_nxt = (r_wcnt != '0) ? S_PKTEND : S_DONE;
      end
      S_PKTEND: if (UsbFull_n) w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_ftmr     <= '0;
      r_run_seen <= 1'b0;
      r_rd_en    <= 1'b0;
      r_slwr_n   <= 1'b1;
      r_pktend_n <= 1'b1;
      r_done     <= 1'b0;
      r_fd       <= '0;
    end else begin
      r_state    <= w_nxt;
      // strobes registered from the next state so they line up with it
      r_rd_en    <= (w_nxt == S_RD);
      r_slwr_n   <= (w_nxt != S_WR);
      r_pktend_n <= !w_pkt_fire;
      // pulses the cycle after DONE, i.e. strictly after any PKTEND strobe
      r_done     <= (r_state == S_DONE);

      if (r_state == S_LOAD) r_fd <= FifoData;

      if (r_state == S_WR)
        r_wcnt <= (r_wcnt == CW'(PKT_WORDS - 1)) ? '0 : r_wcnt + CW'(1);
      else if (w_pkt_fire)
        r_wcnt <= '0;

      // consecutive empty cycles while staying in FLUSH; any exit clears it
      r_ftmr <= (r_state == S_FLUSH && w_nxt == S_FLUSH) ? r_ftmr + TW'(1) : '0;

      if (UsbStartStop)           r_run_seen <= 1'b1;
      else if (r_state == S_DONE) r_run_seen <= 1'b0;
    end
  end

  assign FifoRd_en        = r_rd_en;
  assign UsbFd            = r_fd;
  assign UsbSlwr_n        = r_slwr_n;
  assign UsbPktend_n      = r_pktend_n;
  assign DataTransmitDone = r_done;

endmodule
